adjacency_streamer: RTL and testbench
=====================================

// Module: adjacency_streamer
// PURPOSE
//  Upstream edge source for the path-counting core. Holds the graph in CSR form:
//  a per-node offset table {base,count} and a flat edge list, plus the start/mid0/mid1/end node registers.
//  On run start it emits the header node indices. Per node request it streams the successor indices,
//  one per accepted beat, with a down-counter that reaches 1 on the last edge.
// PARAMETERS
//  PARAM_NODE_IDX_WIDTH   10  node index width; table depth = 2**width
//  PARAM_COUNTER_WIDTH     5  edge-count / down-counter width (max 31 edges per node)
//  PARAM_EDGE_ADDR_WIDTH  12  edge-list address width; edge list depth = 2**width
// PORTS
//  clk         in   1    clock
//  rst_n       in   1    asynchronous active-low reset
//  load_en     in   1    write strobe for graph load
//  load_sel    in   2    0=offset table, 1=edge list, 2=special node reg, 3=reserved (dropped)
//  load_addr   in   EA   node idx / edge addr / special id (0 start, 1 mid0, 2 mid1, 3 end)
//  load_data   in   EA+CW  offset: {base[EA],count[CW]}; edge/special: node idx in the low NW bits
//  load_err    out  1    1-cycle pulse: load dropped (busy or sel=3)
//  run_start   in   1    1-cycle pulse: begin header emission
//  part_sel    in   1    0=part1 (start,end), 1=part2 (start,mid0,mid1,end)
//  req_valid   in   1    node successor request
//  req_node    in   NW   node whose successors are requested
//  req_ready   out  1    high only in IDLE with header done
//  out_valid   out  1    next_node_idx/next_node_counter valid
//  out_ready   in   1    consumer accepts beat
//  next_node_idx      out NW  header or successor index
//  next_node_counter  out CW  beats remaining incl. this one; 1 = last; 0 = node has no edges
//  busy        out  1    not IDLE
// BEHAVIOUR
//  Reset: every output is 0. State is IDLE. Special regs and internal pointers are 0.
//  Memory contents are not reset.
//  States: IDLE -> HDR (run_start) -> IDLE; IDLE -> LOOKUP (req_valid&&req_ready) -> STREAM -> IDLE.
//  HDR: emits start,[mid0,mid1],end. Counter = 4,3,2,1 (part2) or 2,1 (part1).
//   Each beat is held until out_ready. part_sel is sampled at run_start.
//  LOOKUP: 1 cycle. Registers {base,count} of req_node. Edge-read pointer = base.
//  STREAM: the first beat is valid the cycle after LOOKUP. The beat holds while out_valid&&!out_ready.
//   On accept: pointer+1 (mod 2**EA), counter-1. Leaves to IDLE after accepting the beat with counter==1.
//  count==0: one beat, next_node_idx=0, counter=0. Leaves to IDLE on accept.
//  Request-to-first-beat latency = 2 cycles. Sustained throughput = 1 beat/cycle with out_ready high.
//  Edge-list wrap: base+count beyond depth wraps modulo 2**EA. It is not an error.
//  req_valid while !req_ready: ignored. It is not queued; the requester must hold it.
//  run_start while busy: ignored.
//  Load while busy: write dropped, load_err pulses. Load with sel=3: same.
//  Load and run_start in the same IDLE cycle: the write takes effect; the header starts next cycle.
//   The header uses the new value.
//  Async reset mid-stream: immediate return to IDLE, outputs 0. No partial beat is emitted after release.
// STRUCTURE
//  Shared package: state encoding (IDLE/HDR/LOOKUP/STREAM).
//   Also load_sel codes and special-node ids (START/MID0/MID1/END).
//  One sub-module: sdp_ram (1W/1R, registered read, depth/width params).
//   Instantiated twice: offset table and edge list.
//  FSM, special regs, pointer and counter stay in this module.
// TESTING
//  Load specials 5,7,9,3; run_start, part_sel=1 -> beats 5/4, 7/3, 9/2, 3/1.
//   With part_sel=0 -> 5/2, 3/1.
//  Node 5 = {base 10, count 3}, edges[10..12]=7,8,3; req 5 -> first beat 2 cycles later;
//   beats 7/3, 8/2, 3/1; then req_ready=1.
//  Same stream with out_ready toggling 1,0,0,1,... -> beats held stable while stalled.
//   No beats duplicated or lost.
//  Node 2 = {base 4094, count 3}, edges[4094,4095,0]=1,2,3 -> beats 1/3, 2/2, 3/1 (wrap).
//  Node 4 count 0 -> single beat idx 0 / counter 0, back to IDLE.
//   Load during STREAM -> load_err pulse, table unchanged.
//  Assert rst_n low during beat 2 of a 3-edge stream -> all outputs 0. After release: IDLE, req_ready=1.

Source files
------------

// File: rtl/adjacency_streamer_pkg.sv
// Shared definitions for the adjacency streamer.
//   state_e      : FSM state encoding (IDLE/HDR/LOOKUP/STREAM)
//   SEL_*        : load_sel codes for the graph-load port
//   SPEC_*       : special-node register ids used with SEL_SPECIAL
//   *_W_DEFAULT  : default widths for node index, counter and edge address
package adjacency_streamer_pkg;

  localparam int NODE_IDX_W_DEFAULT  = 10;
  localparam int COUNTER_W_DEFAULT   = 5;
  localparam int EDGE_ADDR_W_DEFAULT = 12;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_HDR    = 2'd1,
    ST_LOOKUP = 2'd2,
    ST_STREAM = 2'd3
  } state_e;

  localparam logic [1:0] SEL_OFFSET  = 2'd0;
  localparam logic [1:0] SEL_EDGE    = 2'd1;
  localparam logic [1:0] SEL_SPECIAL = 2'd2;
  localparam logic [1:0] SEL_RSVD    = 2'd3;

  localparam logic [1:0] SPEC_START = 2'd0;
  localparam logic [1:0] SPEC_MID0  = 2'd1;
  localparam logic [1:0] SPEC_MID1  = 2'd2;
  localparam logic [1:0] SPEC_END   = 2'd3;

endpackage

// File: rtl/adjacency_streamer_sdp_ram.sv
// Simple dual-port RAM: one write port, one read port with a registered
// read (data appears the cycle after the address). Contents are not reset.
// Ports:
//   clk      : clock
//   wr_en    : write strobe
//   wr_addr  : write address
//   wr_data  : write data
//   rd_addr  : read address, sampled every cycle
//   rd_data  : registered read data
module adjacency_streamer_sdp_ram #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 17
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
    rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/adjacency_streamer.sv
// Edge source for the path-counting core. Holds the graph in CSR form
// (per-node {base,count} offset table plus flat edge list) and the
// start/mid0/mid1/end special nodes. run_start emits the header nodes;
// a node request streams that node's successors one beat per acceptance,
// with a down-counter that is 1 on the last edge (0 for an edge-less node).
//
// Handshake: a beat transfers on a cycle where out_valid && out_ready; the
// beat (index and counter) holds unchanged while out_valid && !out_ready.
// A request transfers on a cycle where req_valid && req_ready; requests
// seen while req_ready is low are not remembered.
//
// Ports:
//   clk, rst_n          : clock, asynchronous active-low reset
//   load_en/sel/addr/data : graph load port; load_err pulses when dropped
//   run_start, part_sel : begin header emission, part1(0)/part2(1)
//   req_valid/req_node/req_ready : successor request
//   out_valid/out_ready, next_node_idx, next_node_counter : output beats
//   busy                : FSM not idle
//   state_dbg           : current FSM state
module adjacency_streamer
  import adjacency_streamer_pkg::*;
#(
  parameter int NW = NODE_IDX_W_DEFAULT,
  parameter int CW = COUNTER_W_DEFAULT,
  parameter int EA = EDGE_ADDR_W_DEFAULT
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load_en,
  input  logic [1:0]    load_sel,
  input  logic [EA-1:0] load_addr,
  input  logic [EA+CW-1:0] load_data,
  output logic          load_err,
  input  logic          run_start,
  input  logic          part_sel,
  input  logic          req_valid,
  input  logic [NW-1:0] req_node,
  output logic          req_ready,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [NW-1:0] next_node_idx,
  output logic [CW-1:0] next_node_counter,
  output logic          busy,
  output logic [1:0]    state_dbg
);

  state_e        state_q, state_d;
  logic [NW-1:0] spec_q [4];
  logic          part_q;
  logic [1:0]    hdr_i_q;
  logic [EA-1:0] ptr_q;
  logic [CW-1:0] cnt_q;
  logic          load_err_q;

  logic          idle;
  logic          load_ok;
  logic [EA+CW-1:0] off_rd_data;
  logic [EA-1:0] off_base;
  logic [CW-1:0] off_count;
  logic [EA-1:0] edge_rd_addr;
  logic [NW-1:0] edge_rd_data;
  logic [NW-1:0] hdr_idx;
  logic [CW-1:0] hdr_ctr;

  assign idle      = (state_q == ST_IDLE);
  assign load_ok   = load_en && idle && (load_sel != SEL_RSVD);
  assign off_base  = off_rd_data[EA+CW-1:CW];
  assign off_count = off_rd_data[CW-1:0];

  // Offset table is read every cycle at req_node, so in LOOKUP its output
  // holds the entry of the node accepted in the previous cycle.
  adjacency_streamer_sdp_ram #(.ADDR_W(NW), .DATA_W(EA+CW)) u_offset_ram (
    .clk     (clk),
    .wr_en   (load_ok && (load_sel == SEL_OFFSET)),
    .wr_addr (load_addr[NW-1:0]),
    .wr_data (load_data),
    .rd_addr (req_node),
    .rd_data (off_rd_data)
  );

  adjacency_streamer_sdp_ram #(.ADDR_W(EA), .DATA_W(NW)) u_edge_ram (
    .clk     (clk),
    .wr_en   (load_ok && (load_sel == SEL_EDGE)),
    .wr_addr (load_addr),
    .wr_data (load_data[NW-1:0]),
    .rd_addr (edge_rd_addr),
    .rd_data (edge_rd_data)
  );

  // Header beat selection: part2 walks all four specials, part1 only
  // start then end. Counter counts down to 1 on the end node.
  always_comb begin
    hdr_idx = spec_q[SPEC_START];
    hdr_ctr = '0;
    if (part_q) begin
      hdr_idx = spec_q[hdr_i_q];
      hdr_ctr = CW'(3'd4 - {1'b0, hdr_i_q});
    end else begin
      hdr_idx = (hdr_i_q == 2'd0) ? spec_q[SPEC_START] : spec_q[SPEC_END];
      hdr_ctr = (hdr_i_q == 2'd0) ? CW'(2) : CW'(1);
    end
  end

  always_comb begin
    state_d           = state_q;
    out_valid         = 1'b0;
    next_node_idx     = '0;
    next_node_counter = '0;
    edge_rd_addr      = ptr_q;
    case (state_q)
      ST_IDLE: begin
        if (run_start) begin
          state_d = ST_HDR;
        end else if (req_valid) begin
          state_d = ST_LOOKUP;
        end
      end
      ST_HDR: begin
        out_valid         = 1'b1;
        next_node_idx     = hdr_idx;
        next_node_counter = hdr_ctr;
        if (out_ready && (hdr_ctr == CW'(1))) begin
          state_d = ST_IDLE;
        end
      end
      ST_LOOKUP: begin
        // Prefetch the first edge so it is valid in the first STREAM cycle.
        edge_rd_addr = off_base;
        state_d      = ST_STREAM;
      end
      ST_STREAM: begin
        out_valid = 1'b1;
        if (cnt_q == '0) begin
          if (out_ready) begin
            state_d = ST_IDLE;
          end
        end else begin
          next_node_idx     = edge_rd_data;
          next_node_counter = cnt_q;
          // On accept fetch the following edge; while stalled re-read the
          // current one so the beat holds (edge list cannot change while busy).
          if (out_ready) begin
            edge_rd_addr = ptr_q + EA'(1);
            if (cnt_q == CW'(1)) begin
              state_d = ST_IDLE;
            end
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      part_q     <= 1'b0;
      hdr_i_q    <= 2'd0;
      ptr_q      <= '0;
      cnt_q      <= '0;
      load_err_q <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        spec_q[i] <= '0;
      end
    end else begin
      state_q    <= state_d;
      load_err_q <= load_en && (!idle || (load_sel == SEL_RSVD));
      if (load_ok && (load_sel == SEL_SPECIAL)) begin
        spec_q[load_addr[1:0]] <= load_data[NW-1:0];
      end
      case (state_q)
        ST_IDLE: begin
          if (run_start) begin
            part_q  <= part_sel;
            hdr_i_q <= 2'd0;
          end
        end
        ST_HDR: begin
          if (out_ready) begin
            hdr_i_q <= hdr_i_q + 2'd1;
          end
        end
        ST_LOOKUP: begin
          ptr_q <= off_base;
          cnt_q <= off_count;
        end
        ST_STREAM: begin
          if (out_ready) begin
            ptr_q <= ptr_q + EA'(1);
            if (cnt_q != '0) begin
              cnt_q <= cnt_q - CW'(1);
            end
          end
        end
        default: ;
      endcase
    end
  end

  // req_ready is gated by rst_n so every output reads 0 during reset, and
  // by run_start because the header wins a same-cycle tie.
  assign req_ready = rst_n && idle && !run_start;
  assign busy      = !idle;
  assign load_err  = load_err_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_adjacency_streamer.sv
// Bench for adjacency_streamer: reference model of the CSR graph in plain
// arrays; expected beat sequences are derived from {base,count} and the
// edge list with modular arithmetic.
module tb_adjacency_streamer;

  localparam int NW = 10;
  localparam int CW = 5;
  localparam int EA = 12;
  localparam int BW = NW + CW;

  logic          clk;
  logic          rst_n;
  logic          load_en;
  logic [1:0]    load_sel;
  logic [EA-1:0] load_addr;
  logic [EA+CW-1:0] load_data;
  logic          load_err;
  logic          run_start;
  logic          part_sel;
  logic          req_valid;
  logic [NW-1:0] req_node;
  logic          req_ready;
  logic          out_valid;
  logic          out_ready;
  logic [NW-1:0] next_node_idx;
  logic [CW-1:0] next_node_counter;
  logic          busy;
  logic [1:0]    state_dbg;

  adjacency_streamer dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .load_en           (load_en),
    .load_sel          (load_sel),
    .load_addr         (load_addr),
    .load_data         (load_data),
    .load_err          (load_err),
    .run_start         (run_start),
    .part_sel          (part_sel),
    .req_valid         (req_valid),
    .req_node          (req_node),
    .req_ready         (req_ready),
    .out_valid         (out_valid),
    .out_ready         (out_ready),
    .next_node_idx     (next_node_idx),
    .next_node_counter (next_node_counter),
    .busy              (busy),
    .state_dbg         (state_dbg)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  int          m_base [1024];
  int          m_cnt  [1024];
  int          m_edge [4096];
  int          m_spec [4];

  logic [BW-1:0] exp_q [$];
  logic [BW-1:0] got_q [$];
  int            hold_viol;
  bit            timed_out;

  int n_vec;
  int n_err;

  function automatic logic [BW-1:0] beat(input int idx, input int ctr);
    beat = {NW'(idx), CW'(ctr)};
  endfunction

  task automatic build_stream_exp(input int node);
    exp_q.delete();
    if (m_cnt[node] == 0) begin
      exp_q.push_back(beat(0, 0));
    end else begin
      for (int i = 0; i < m_cnt[node]; i++) begin
        exp_q.push_back(beat(m_edge[(m_base[node] + i) % 4096], m_cnt[node] - i));
      end
    end
  endtask

  task automatic build_hdr_exp(input bit part2);
    exp_q.delete();
    if (part2) begin
      for (int i = 0; i < 4; i++) exp_q.push_back(beat(m_spec[i], 4 - i));
    end else begin
      exp_q.push_back(beat(m_spec[0], 2));
      exp_q.push_back(beat(m_spec[3], 1));
    end
  endtask

  // ---------------- driver tasks ----------------
  // All drivers are entered and left at a negedge.
  task automatic do_load(input logic [1:0] sel, input int addr, input int data);
    load_en = 1'b1; load_sel = sel; load_addr = EA'(addr); load_data = (EA+CW)'(data);
    @(negedge clk);
    load_en = 1'b0;
  endtask

  task automatic load_off(input int node, input int base, input int cnt);
    do_load(2'd0, node, (base << CW) | cnt);
    m_base[node] = base;
    m_cnt[node]  = cnt;
  endtask

  task automatic load_edge(input int addr, input int val);
    do_load(2'd1, addr, val);
    m_edge[addr] = val;
  endtask

  task automatic load_spec(input int id, input int val);
    do_load(2'd2, id, val);
    m_spec[id] = val;
  endtask

  task automatic do_run(input bit p);
    run_start = 1'b1; part_sel = p;
    @(negedge clk);
    run_start = 1'b0;
  endtask

  // Returns at the negedge of the LOOKUP cycle.
  task automatic send_req(input int node);
    req_valid = 1'b1; req_node = NW'(node);
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  // Gathers n accepted beats into got_q; mode 0 ready always, 1 pattern
  // 1,0,0 repeating, 2 random. Counts beats that changed while stalled.
  task automatic collect(input int n, input int mode);
    bit            prev_stall;
    logic [BW-1:0] prev_beat;
    int            cyc;
    got_q.delete();
    hold_viol = 0; timed_out = 1'b0; prev_stall = 1'b0; cyc = 0; prev_beat = '0;
    while (got_q.size() < n) begin
      if (cyc > 500) begin
        timed_out = 1'b1;
        break;
      end
      if (prev_stall && (!out_valid || {next_node_idx, next_node_counter} !== prev_beat))
        hold_viol++;
      case (mode)
        0:       out_ready = 1'b1;
        1:       out_ready = (cyc % 3 == 0);
        default: out_ready = 1'($urandom_range(0, 1));
      endcase
      if (out_valid && out_ready) got_q.push_back({next_node_idx, next_node_counter});
      prev_stall = out_valid && !out_ready;
      prev_beat  = {next_node_idx, next_node_counter};
      @(negedge clk);
      cyc++;
    end
    out_ready = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset;
    rst_n = 1'b0;
    #2;
    n_vec++;
    if ({out_valid, req_ready, busy, load_err, next_node_idx, next_node_counter} !== '0) begin
      n_err++;
      $display("FAIL reset_outputs: got v=%b rr=%b busy=%b le=%b idx=%0d ctr=%0d, want all 0",
               out_valid, req_ready, busy, load_err, next_node_idx, next_node_counter);
    end
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    n_vec++;
    if (req_ready !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL reset_release: got rr=%b busy=%b v=%b, want 1 0 0", req_ready, busy, out_valid);
    end
  endtask

  task automatic test_header;
    load_spec(0, 5); load_spec(1, 7); load_spec(2, 9); load_spec(3, 3);
    // part2 with a run_start retrigger while busy that must be ignored
    do_run(1'b1);
    n_vec++;
    if (busy !== 1'b1 || req_ready !== 1'b0) begin
      n_err++;
      $display("FAIL hdr_busy: got busy=%b rr=%b, want 1 0", busy, req_ready);
    end
    do_run(1'b0);
    build_hdr_exp(1'b1);
    collect(exp_q.size(), 2);
    n_vec++;
    if (timed_out || hold_viol != 0) begin
      n_err++;
      $display("FAIL hdr_p2_flow: timeout=%0d hold_viol=%0d, want 0 0", timed_out, hold_viol);
    end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      n_vec++;
      if (got_q[i] !== exp_q[i]) begin
        n_err++;
        $display("FAIL hdr_p2_beat%0d: got %0d/%0d, want %0d/%0d", i,
                 got_q[i][BW-1:CW], got_q[i][CW-1:0], exp_q[i][BW-1:CW], exp_q[i][CW-1:0]);
      end
    end
    n_vec++;
    if (out_valid !== 1'b0 || req_ready !== 1'b1) begin
      n_err++;
      $display("FAIL hdr_p2_end: got v=%b rr=%b, want 0 1", out_valid, req_ready);
    end
    do_run(1'b0);
    build_hdr_exp(1'b0);
    collect(exp_q.size(), 0);
    for (int i = 0; i < exp_q.size(); i++) begin
      n_vec++;
      if (timed_out || got_q[i] !== exp_q[i]) begin
        n_err++;
        $display("FAIL hdr_p1_beat%0d: got %h, want %h (timeout=%0d)", i, got_q[i], exp_q[i], timed_out);
      end
    end
    n_vec++;
    if (out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL hdr_p1_end: got v=%b, want 0", out_valid);
    end
  endtask

  task automatic test_load_and_run;
    // Same-cycle special write and run_start: header sees the new start.
    load_en = 1'b1; load_sel = 2'd2; load_addr = '0; load_data = 17'd11;
    run_start = 1'b1; part_sel = 1'b0;
    m_spec[0] = 11;
    @(negedge clk);
    load_en = 1'b0; run_start = 1'b0;
    n_vec++;
    if (load_err !== 1'b0) begin
      n_err++;
      $display("FAIL load_run_err: got %b, want 0", load_err);
    end
    build_hdr_exp(1'b0);
    collect(exp_q.size(), 0);
    for (int i = 0; i < exp_q.size(); i++) begin
      n_vec++;
      if (timed_out || got_q[i] !== exp_q[i]) begin
        n_err++;
        $display("FAIL load_run_beat%0d: got %h, want %h", i, got_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic check_stream(input string name, input int node, input int mode);
    build_stream_exp(node);
    send_req(node);
    collect(exp_q.size(), mode);
    n_vec++;
    if (timed_out || hold_viol != 0 || got_q.size() != exp_q.size()) begin
      n_err++;
      $display("FAIL %s_flow: timeout=%0d hold_viol=%0d beats=%0d, want 0 0 %0d",
               name, timed_out, hold_viol, got_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      n_vec++;
      if (got_q[i] !== exp_q[i]) begin
        n_err++;
        $display("FAIL %s_beat%0d: got %0d/%0d, want %0d/%0d", name, i,
                 got_q[i][BW-1:CW], got_q[i][CW-1:0], exp_q[i][BW-1:CW], exp_q[i][CW-1:0]);
      end
    end
    n_vec++;
    if (out_valid !== 1'b0 || req_ready !== 1'b1) begin
      n_err++;
      $display("FAIL %s_end: got v=%b rr=%b, want 0 1", name, out_valid, req_ready);
    end
  endtask

  task automatic test_stream_basic;
    load_off(5, 10, 3);
    load_edge(10, 7); load_edge(11, 8); load_edge(12, 3);
    build_stream_exp(5);
    n_vec++;
    if (req_ready !== 1'b1) begin
      n_err++;
      $display("FAIL basic_req_ready: got %b, want 1", req_ready);
    end
    send_req(5);
    n_vec++;
    if (out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL basic_latency1: got v=%b one cycle after request, want 0", out_valid);
    end
    @(negedge clk);
    n_vec++;
    if (out_valid !== 1'b1 || {next_node_idx, next_node_counter} !== exp_q[0]) begin
      n_err++;
      $display("FAIL basic_latency2: got v=%b beat %0d/%0d, want 1 %0d/%0d", out_valid,
               next_node_idx, next_node_counter, exp_q[0][BW-1:CW], exp_q[0][CW-1:0]);
    end
    collect(exp_q.size(), 0);
    for (int i = 0; i < exp_q.size(); i++) begin
      n_vec++;
      if (timed_out || got_q[i] !== exp_q[i]) begin
        n_err++;
        $display("FAIL basic_beat%0d: got %h, want %h", i, got_q[i], exp_q[i]);
      end
    end
    n_vec++;
    if (out_valid !== 1'b0 || req_ready !== 1'b1) begin
      n_err++;
      $display("FAIL basic_end: got v=%b rr=%b, want 0 1", out_valid, req_ready);
    end
  endtask

  task automatic test_stall;
    check_stream("stall", 5, 1);
  endtask

  task automatic test_wrap;
    load_off(2, 4094, 3);
    load_edge(4094, 1); load_edge(4095, 2); load_edge(0, 3);
    check_stream("wrap", 2, 0);
  endtask

  task automatic test_zero_count;
    load_off(4, 100, 0);
    send_req(4);
    @(negedge clk);
    // Stalled in STREAM: a load must be dropped and flagged.
    do_load(2'd0, 4, (200 << CW) | 5);
    n_vec++;
    if (load_err !== 1'b1) begin
      n_err++;
      $display("FAIL busy_load_err: got %b, want 1", load_err);
    end
    @(negedge clk);
    n_vec++;
    if (load_err !== 1'b0) begin
      n_err++;
      $display("FAIL busy_load_err_pulse: got %b, want 0", load_err);
    end
    build_stream_exp(4);
    collect(1, 0);
    n_vec++;
    if (timed_out || got_q[0] !== exp_q[0]) begin
      n_err++;
      $display("FAIL zero_beat: got %h, want %h", got_q[0], exp_q[0]);
    end
    n_vec++;
    if (out_valid !== 1'b0 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL zero_end: got v=%b busy=%b, want 0 0", out_valid, busy);
    end
    check_stream("zero_again", 4, 2);
    // Reserved select is dropped even in IDLE.
    do_load(2'd3, 4, (300 << CW) | 7);
    n_vec++;
    if (load_err !== 1'b1 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL rsvd_load: got err=%b busy=%b, want 1 0", load_err, busy);
    end
    check_stream("rsvd_unchanged", 4, 0);
  endtask

  task automatic test_random;
    int nodes [8];
    for (int k = 0; k < 8; k++) begin
      nodes[k] = 20 + k * 37 + int'($urandom_range(0, 30));
      load_off(nodes[k], int'($urandom_range(0, 4095)), int'($urandom_range(0, 31)));
      for (int i = 0; i < m_cnt[nodes[k]]; i++)
        load_edge((m_base[nodes[k]] + i) % 4096, int'($urandom_range(0, 1023)));
    end
    for (int r = 0; r < 12; r++) begin
      check_stream($sformatf("rand%0d", r), nodes[$urandom_range(0, 7)], 2);
    end
  endtask

  task automatic test_reset_mid;
    check_stream("pre_rst", 5, 0);
    build_stream_exp(5);
    send_req(5);
    collect(1, 0);
    n_vec++;
    if (out_valid !== 1'b1 || {next_node_idx, next_node_counter} !== exp_q[1]) begin
      n_err++;
      $display("FAIL rst_mid_beat2: got v=%b %0d/%0d, want 1 %h", out_valid,
               next_node_idx, next_node_counter, exp_q[1]);
    end
    #1 rst_n = 1'b0;
    #1;
    n_vec++;
    if ({out_valid, req_ready, busy, load_err, next_node_idx, next_node_counter} !== '0) begin
      n_err++;
      $display("FAIL rst_mid_outputs: got v=%b rr=%b busy=%b le=%b idx=%0d ctr=%0d, want all 0",
               out_valid, req_ready, busy, load_err, next_node_idx, next_node_counter);
    end
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      n_vec++;
      if (out_valid !== 1'b0 || req_ready !== 1'b1 || busy !== 1'b0) begin
        n_err++;
        $display("FAIL rst_mid_after%0d: got v=%b rr=%b busy=%b, want 0 1 0",
                 i, out_valid, req_ready, busy);
      end
    end
    out_ready = 1'b0;
  endtask

  // ---------------- main sequence / report ----------------
  initial begin
    n_vec = 0; n_err = 0;
    rst_n = 1'b0; load_en = 1'b0; load_sel = '0; load_addr = '0; load_data = '0;
    run_start = 1'b0; part_sel = 1'b0; req_valid = 1'b0; req_node = '0; out_ready = 1'b0;
    for (int i = 0; i < 4; i++) m_spec[i] = 0;
    @(negedge clk);
    test_reset();
    test_header();
    test_load_and_run();
    test_stream_basic();
    test_stall();
    test_wrap();
    test_zero_count();
    test_random();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
